// File: rtl/manch_pkg.sv
// Shared types and constants for the Manchester transmitter.
package manch_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SEND_BIT,
    EOF
  } mtx_state_t;

  localparam logic IDLE_LEVEL = 1'b1;

endpackage

// File: rtl/manch_tx_half_bit_tick.sv
// Half-bit period generator: tick marks the last clock of each half-bit.
module half_bit_tick #(
  parameter int CLK_FREQ = 100_000_000,
  parameter int BIT_RATE = 50_000
) (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  output logic tick
);

  localparam int HALF_CNT = CLK_FREQ / (2 * BIT_RATE);
  localparam int CNT_W    = (HALF_CNT > 1) ? $clog2(HALF_CNT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(HALF_CNT - 1);

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt <= '0;
    end else if (clr || (cnt == CNT_LAST)) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + CNT_W'(1);
    end
  end

  assign tick = (cnt == CNT_LAST);

endmodule

// File: rtl/manch_tx.sv
// Double-buffered Manchester serial transmitter with end-of-frame marker.
module manch_tx
  import manch_pkg::*;
#(
  parameter int CLK_FREQ = 100_000_000,
  parameter int BIT_RATE = 50_000,
  parameter int EOF_BITS = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       send,
  input  logic [7:0] data,
  output logic       ready,
  output logic       txd,
  output logic       txen
);

  localparam int HALF_CNT = CLK_FREQ / (2 * BIT_RATE);
  localparam int EOF_LEN  = EOF_BITS * 2 * HALF_CNT;
  localparam int EOF_W    = $clog2(EOF_LEN);
  localparam logic [EOF_W-1:0] EOF_LAST = EOF_W'(EOF_LEN - 1);

  mtx_state_t       state;
  logic [7:0]       hold;
  logic             hold_full;
  logic [7:0]       shift;
  logic             half;
  logic [2:0]       bit_idx;
  logic [EOF_W-1:0] eof_cnt;

  logic tick;
  logic bit_end;
  logic last_bit;
  logic xfer;
  logic eof_entry;
  logic eof_done;
  logic tick_clr;

  half_bit_tick #(
    .CLK_FREQ(CLK_FREQ),
    .BIT_RATE(BIT_RATE)
  ) u_tick (
    .clk  (clk),
    .reset(reset),
    .clr  (tick_clr),
    .tick (tick)
  );

  always_comb begin
    bit_end   = (state == SEND_BIT) && tick && half;
    last_bit  = bit_end && (bit_idx == 3'd7);
    xfer      = hold_full && ((state == IDLE) || last_bit);
    eof_entry = last_bit && !hold_full;
    eof_done  = (state == EOF) && (eof_cnt == EOF_LAST);
    tick_clr  = xfer || eof_entry;
  end

  assign ready = ~hold_full;

  // Control: FSM, buffer flag, counters and registered line outputs
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      hold_full <= 1'b0;
      half      <= 1'b0;
      bit_idx   <= 3'd0;
      eof_cnt   <= '0;
      txd       <= IDLE_LEVEL;
      txen      <= 1'b0;
    end else begin
      if (xfer) begin
        hold_full <= 1'b0;
      end else if (send && !hold_full) begin
        hold_full <= 1'b1;
      end

      if (xfer) begin
        state   <= SEND_BIT;
        half    <= 1'b0;
        bit_idx <= 3'd0;
        txd     <= ~hold[0];
        txen    <= 1'b1;
      end else begin
        case (state)
          SEND_BIT: begin
            if (tick) begin
              if (!half) begin
                half <= 1'b1;
                txd  <= shift[0];
              end else if (bit_idx == 3'd7) begin
                // hold is empty here, otherwise xfer would have fired
                state   <= EOF;
                half    <= 1'b0;
                eof_cnt <= '0;
                txd     <= IDLE_LEVEL;
              end else begin
                half    <= 1'b0;
                bit_idx <= bit_idx + 3'd1;
                txd     <= ~shift[1];
              end
            end
          end
          EOF: begin
            if (eof_done) begin
              state   <= IDLE;
              eof_cnt <= '0;
              txen    <= 1'b0;
            end else begin
              eof_cnt <= eof_cnt + EOF_W'(1);
            end
          end
          default: begin
            txd  <= IDLE_LEVEL;
            txen <= 1'b0;
          end
        endcase
      end
    end
  end

  // Data: holding and shift registers, no reset needed
  always_ff @(posedge clk) begin
    if (send && !hold_full) begin
      hold <= data;
    end
    if (xfer) begin
      shift <= hold;
    end else if (bit_end) begin
      shift <= shift >> 1;
    end
  end

endmodule

// File: tb/tb_manch_tx.sv
// Bench for manch_tx: cycle-accurate line model plus an independent line decoder.
module tb_manch_tx;

  localparam int CLK_FREQ = 100;
  localparam int BIT_RATE = 10;
  localparam int EOF_BITS = 2;
  localparam int HALF     = CLK_FREQ / (2 * BIT_RATE);
  localparam int BIT_CLKS = 2 * HALF;
  localparam int EOF_LEN  = EOF_BITS * BIT_CLKS;

  typedef struct packed {
    logic first;
    logic dat;
    logic en;
    logic d;
  } samp_t;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       send = 1'b0;
  logic [7:0] data = 8'h00;
  logic       ready;
  logic       txd;
  logic       txen;

  int errors = 0;
  int checks = 0;

  samp_t      exp_q[$];
  logic [7:0] sent_q[$];
  logic       rx_bits[$];
  logic       mready = 1'b1;
  logic       prev_en = 1'b0;
  int         dec_cnt = 0;
  int         fr_cnt = 0;

  manch_tx #(
    .CLK_FREQ(CLK_FREQ),
    .BIT_RATE(BIT_RATE),
    .EOF_BITS(EOF_BITS)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .send (send),
    .data (data),
    .ready(ready),
    .txd  (txd),
    .txen (txen)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic samp_t mk(input logic first, input logic dat, input logic en, input logic d);
    samp_t s;
    s.first = first;
    s.dat   = dat;
    s.en    = en;
    s.d     = d;
    return s;
  endfunction

  // A byte accepted on the coming edge: chain after pending data bits, or open a new frame.
  task automatic model_accept(input logic [7:0] b);
    samp_t seg[$];
    int    drem;
    for (int i = 0; i < 8; i++)
      for (int h = 0; h < 2; h++)
        for (int k = 0; k < HALF; k++)
          seg.push_back(mk((i == 0 && h == 0 && k == 0), 1'b1, 1'b1, h ? b[i] : ~b[i]));
    sent_q.push_back(b);
    drem = 0;
    while (drem < exp_q.size() && exp_q[drem].dat) drem++;
    if (drem > 0) begin
      for (int j = 0; j < seg.size(); j++) exp_q.insert(drem + j, seg[j]);
    end else begin
      exp_q.push_back(mk(1'b0, 1'b0, 1'b0, 1'b1));
      for (int j = 0; j < seg.size(); j++) exp_q.push_back(seg[j]);
      for (int j = 0; j < EOF_LEN; j++) exp_q.push_back(mk(1'b0, 1'b0, 1'b1, 1'b1));
    end
  endtask

  task automatic decode_end();
    int         nb;
    logic [7:0] rb;
    logic [7:0] eb;
    nb = (dec_cnt - EOF_LEN) / (8 * BIT_CLKS);
    chk("frame_len", dec_cnt, nb * 8 * BIT_CLKS + EOF_LEN);
    for (int i = 0; i < nb; i++) begin
      for (int j = 0; j < 8; j++) rb[j] = (8 * i + j < rx_bits.size()) ? rx_bits[8 * i + j] : 1'bx;
      eb = (sent_q.size() > 0) ? sent_q.pop_front() : ~rb;
      chk("rx_byte", rb, eb);
    end
    for (int j = 8 * nb; j < rx_bits.size(); j++) chk("eof_level", rx_bits[j], 1'b1);
  endtask

  task automatic step();
    samp_t s;
    if (send && mready) model_accept(data);
    @(negedge clk);
    s = (exp_q.size() > 0) ? exp_q.pop_front() : mk(1'b0, 1'b0, 1'b0, 1'b1);
    fr_cnt = s.en ? fr_cnt + 1 : 0;
    mready = 1'b1;
    foreach (exp_q[i]) if (exp_q[i].first) mready = 1'b0;
    chk("txen", txen, s.en);
    chk("txd", txd, s.d);
    chk("ready", ready, mready);
    if (txen === 1'b1) begin
      if (!prev_en) begin
        dec_cnt = 0;
        rx_bits.delete();
      end
      if (dec_cnt % BIT_CLKS == HALF + 2) rx_bits.push_back(txd);
      dec_cnt++;
    end else if (prev_en) begin
      decode_end();
    end
    prev_en = (txen === 1'b1);
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic drive_byte(input logic [7:0] b);
    int g = 0;
    while (!mready && g < 2000) begin
      step();
      g++;
    end
    chk("ready_timeout", (g < 2000), 1'b1);
    send = 1'b1;
    data = b;
    step();
    send = 1'b0;
    data = 8'($urandom);
  endtask

  task automatic wait_idle();
    int g = 0;
    while (exp_q.size() > 0 && g < 3000) begin
      step();
      g++;
    end
    chk("idle_timeout", exp_q.size(), 0);
    steps(3);
  endtask

  task automatic wait_fr(input int target);
    int g = 0;
    while (fr_cnt != target && g < 2000) begin
      step();
      g++;
    end
    chk("frame_pos_timeout", fr_cnt, target);
  endtask

  initial begin
    // Reset and quiet idle
    steps(3);
    reset = 1'b0;
    steps(100);

    // Single byte
    drive_byte(8'hA5);
    wait_idle();

    // Back-to-back burst
    drive_byte(8'hAA);
    drive_byte(8'h00);
    drive_byte(8'hAA);
    wait_idle();

    // Held send while the holding register is full
    drive_byte(8'h3C);
    drive_byte(8'hC3);
    send = 1'b1;
    for (int i = 0; i < 40; i++) begin
      data = 8'($urandom);
      step();
    end
    send = 1'b0;
    wait_idle();

    // Asynchronous reset in the middle of bit 3 of the second byte
    drive_byte(8'($urandom));
    drive_byte(8'($urandom));
    drive_byte(8'($urandom));
    wait_fr(8 * BIT_CLKS + 1 + 3 * BIT_CLKS + 3);
    #2 reset = 1'b1;
    #1;
    chk("rst_txd", txd, 1'b1);
    chk("rst_txen", txen, 1'b0);
    chk("rst_ready", ready, 1'b1);
    exp_q.delete();
    sent_q.delete();
    rx_bits.delete();
    mready  = 1'b1;
    prev_en = 1'b0;
    fr_cnt  = 0;
    steps(3);
    reset = 1'b0;
    steps(5);
    drive_byte(8'h55);
    wait_idle();

    // New byte offered during EOF cycle 7
    drive_byte(8'($urandom));
    wait_fr(8 * BIT_CLKS + 7);
    drive_byte(8'($urandom));
    wait_idle();

    // Random frames with random inter-byte gaps
    for (int f = 0; f < 4; f++) begin
      int n;
      n = int'($urandom_range(1, 4));
      for (int i = 0; i < n; i++) begin
        steps(int'($urandom_range(0, 90)));
        drive_byte(8'($urandom));
      end
      wait_idle();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
